ripple_count_sampler: RTL and testbench
=======================================

# ripple_count_sampler

Downstream consumer of the 4-bit ripple (asynchronous T-flip-flop) counter. Samples the counter's unsynchronised `count` bus into the system clock domain and rejects ripple-transition glitches with a stability filter. Converts each accepted value change into a modulo-16 increment and accumulates the increments into a wide event total, with sticky threshold and overflow flags. It sits between the ripple counter and any register or interrupt logic that reads event totals.

## Interface
- `TOTAL_W`, default 16: width of the accumulated total (8..32).
- `STABLE_N`, default 2: number of consecutive identical synchronised samples required before a value is accepted (2..4).

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `count_in` in 4: ripple counter output, asynchronous to `clk`.
- `clr` in 1: synchronous clear of `total`, `thresh_hit` and `overflow`.
- `threshold` in TOTAL_W: compare value for `thresh_hit`; quasi-static.
- `count_sync` out 4: last accepted counter value.
- `delta` out 4: increment of the last acceptance, (new − old) mod 16.
- `delta_valid` out 1: one-cycle pulse on each acceptance.
- `total` out TOTAL_W: accumulated events, wraps modulo 2^TOTAL_W.
- `thresh_hit` out 1: sticky; set when `total` ≥ `threshold`.
- `overflow` out 1: sticky; set on carry-out of `total`.

## Operation
- **Synchroniser:** two flops, `s1 <= count_in` and `s2 <= s1`. Then `s3 <= s2` is kept for change detection. Each bit is synchronised independently; the stability filter removes incoherent multi-bit samples.
- **Run-length filter, `run_len` (1..STABLE_N, saturating):**
  - If `s2 != s3`, `run_len <= 1`.
  - Otherwise `run_len <= min(run_len+1, STABLE_N)`.
  - States: TRACK while `run_len < STABLE_N`; STABLE when `run_len == STABLE_N`.
- **Acceptance:** occurs on a cycle where the state is STABLE and `s2 != count_sync`. On that edge:
  - `count_sync <= s2`.
  - `delta <= s2 − count_sync` (4-bit, wraps).
  - `delta_valid <= 1`; it is 0 on all other cycles.
  - `{carry, total} <= total + delta` (zero-extended). `overflow <= 1` if carry.
  - At most one acceptance per cycle. An unchanged stable value produces no acceptance.
- **Threshold:** `thresh_hit <= 1` on any cycle where the registered `total >= threshold`. The flag is sticky until `clr` or `reset`. Changing `threshold` never clears it.
- **Clear (`clr = 1`):**
  - `total <= 0`, `thresh_hit <= 0`, `overflow <= 0`.
  - The `thresh_hit` compare is suppressed that cycle.
  - `count_sync`, the synchroniser and `run_len` are not affected, so the baseline is kept and no spurious delta appears.
- **`clr` coinciding with an acceptance:**
  - `count_sync`, `delta` and `delta_valid` update normally.
  - `total` = 0, and the increment is discarded.
  - `overflow` = 0.
- **Reset:** `s1`, `s2`, `s3`, `count_sync`, `delta`, `total` = 0; `delta_valid`, `thresh_hit`, `overflow` = 0; `run_len` = 1 (TRACK).
  - The ripple counter shares this reset, so the baseline after reset is 0.
  - Reset overrides `clr` and any acceptance.
- **Rate limit:** correctness requires the ripple counter to advance fewer than 16 counts between acceptances, i.e. fewer than 16 counts per STABLE_N+2 clocks. Faster input aliases and is not detected.

## Timing
- A `count_in` value stable from before edge E:
  - `s1` at edge E, `s2` at E+1, `run_len`=1 at E+2, STABLE at E+STABLE_N+1.
  - `count_sync`, `delta`, `delta_valid` and `total` visible after edge E+STABLE_N+2. For STABLE_N=2 that is 4 edges.
  - `thresh_hit` and the compare that follows a new `total` are visible after edge E+STABLE_N+3.
- `overflow` is set on the same edge as the wrapping `total` update.
- `clr` takes effect on the edge where it is sampled high. The outputs read 0 the next cycle.
- A glitch value that reaches `s2` for fewer than STABLE_N consecutive cycles is never accepted.

## Test plan
- **Reset:** assert `reset` with `count_in`=4'hA → all outputs 0 during and one cycle after reset. No `delta_valid` until 4'hA has been stable for STABLE_N+2 edges. Then `count_sync`=4'hA, `delta`=10, `total`=10.
- **Increment and wrap:** step `count_in` 0→3 (held 6 clk), then 3→1 (held 6 clk) → `delta`=3, then `delta`=14 (wrap); `total`=3, then 17; exactly two `delta_valid` pulses.
- **Glitch rejection:** `count_in` 0→7 for 1 clk, then back to 0 (STABLE_N=2) → no `delta_valid`; `count_sync`=0; `total` unchanged.
- **Threshold:** `threshold`=20, ramp `count_in` by +1 every 6 clk → `thresh_hit` rises one cycle after `total` reaches 20. It stays high after `threshold`=100. It drops only on `clr`.
- **Overflow:** TOTAL_W=8, preload via increments to `total`=250, then `delta`=9 → `total`=3, `overflow`=1 on the same edge; `clr` → `total`=0, `overflow`=0, `thresh_hit`=0.
- **`clr` with acceptance:** assert `clr` on the acceptance cycle of 5→9 → `delta_valid`=1, `delta`=4, `count_sync`=9, `total`=0. The next step 9→B gives `total`=2.

Source files
------------

// File: rtl/ripple_count_sampler.sv
// Samples a free-running 4-bit ripple counter into the clk domain, filters ripple
// glitches, and accumulates accepted count changes into a wide event total.
module ripple_count_sampler #(
  parameter int TOTAL_W  = 16,
  parameter int STABLE_N = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         count_in,
  input  logic               clr,
  input  logic [TOTAL_W-1:0] threshold,
  output logic [3:0]         count_sync,
  output logic [3:0]         delta,
  output logic               delta_valid,
  output logic [TOTAL_W-1:0] total,
  output logic               thresh_hit,
  output logic               overflow
);

  localparam int RUN_W = 3;

  typedef enum logic {TRACK, STABLE} filt_state_t;

  logic [3:0]       s1, s2, s3;
  logic [RUN_W-1:0] run_len, run_len_next;
  filt_state_t      state;
  logic             accept;
  logic [3:0]       delta_next;
  logic [TOTAL_W:0] sum;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state        = TRACK;
    run_len_next = run_len;
    accept       = 1'b0;
    delta_next   = s2 - count_sync;
    sum          = {1'b0, total} + {{(TOTAL_W - 3){1'b0}}, delta_next};

    if (run_len == RUN_W'(STABLE_N)) state = STABLE;

    if (s2 != s3)
      run_len_next = RUN_W'(1);
    else if (state == TRACK)
      run_len_next = run_len + RUN_W'(1);

    // STABLE describes the samples already compared; s2 == s3 keeps a value that has
    // only just reached s2 from being taken before it has a run of its own.
    accept = (state == STABLE) && (s2 == s3) && (s2 != count_sync);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      run_len     <= RUN_W'(1);
      count_sync  <= '0;
      delta       <= '0;
      delta_valid <= 1'b0;
      total       <= '0;
      thresh_hit  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values (s1->s2->s3 shift).
      s1          <= count_in;
      s2          <= s1;
      s3          <= s2;
      run_len     <= run_len_next;
      delta_valid <= accept;

      if (accept) begin
        count_sync <= s2;
        delta      <= delta_next;
      end

      // Clear wins over both the compare and the accumulation, but not the baseline.
      if (clr) begin
        total      <= '0;
        thresh_hit <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (total >= threshold) thresh_hit <= 1'b1;
        if (accept) begin
          total <= sum[TOTAL_W-1:0];
          if (sum[TOTAL_W]) overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Self-checking bench for ripple_count_sampler: directed test-plan scenarios plus a
// randomized phase, all compared each cycle against a sample-history reference model.
module tb_ripple_count_sampler;

  localparam int TW = 8;
  localparam int SN = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    count_in;
  logic          clr;
  logic [TW-1:0] threshold;
  logic [3:0]    count_sync;
  logic [3:0]    delta;
  logic          delta_valid;
  logic [TW-1:0] total;
  logic          thresh_hit;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;
  int dv_count = 0;

  // Reference model: history of the value sampled at each edge (index 0 = newest).
  logic [3:0] hist [8];
  logic [3:0] m_sync  = '0;
  logic [3:0] m_delta = '0;
  logic       m_dv    = 1'b0;
  logic       m_thr   = 1'b0;
  logic       m_ovf   = 1'b0;
  int         m_total = 0;

  ripple_count_sampler #(.TOTAL_W(TW), .STABLE_N(SN)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .clr         (clr),
    .threshold   (threshold),
    .count_sync  (count_sync),
    .delta       (delta),
    .delta_valid (delta_valid),
    .total       (total),
    .thresh_hit  (thresh_hit),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // A value is accepted once the same input has been sampled on SN+1 consecutive
  // edges, seen two edges late through the synchroniser, and differs from the baseline.
  task automatic model_edge();
    logic       stable;
    logic [3:0] d;
    int         sum;
    if (reset) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      m_sync = '0; m_delta = '0; m_dv = 1'b0;
      m_thr = 1'b0; m_ovf = 1'b0; m_total = 0;
    end else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = count_in;
      stable = 1'b1;
      for (int i = 3; i <= SN + 2; i++) if (hist[i] != hist[2]) stable = 1'b0;
      m_dv = stable && (hist[2] != m_sync);
      d = hist[2] - m_sync;
      if (clr) m_thr = 1'b0;
      else if (m_total >= int'(threshold)) m_thr = 1'b1;
      if (m_dv) begin
        m_sync  = hist[2];
        m_delta = d;
      end
      if (clr) begin
        m_total = 0;
        m_ovf   = 1'b0;
      end else if (m_dv) begin
        sum = m_total + int'(d);
        if (sum >= (1 << TW)) m_ovf = 1'b1;
        m_total = sum % (1 << TW);
      end
    end
  endtask

  task automatic compare_all();
    check("count_sync",  32'(count_sync),  32'(m_sync));
    check("delta",       32'(delta),       32'(m_delta));
    check("delta_valid", 32'(delta_valid), 32'(m_dv));
    check("total",       32'(total),       32'(m_total));
    check("thresh_hit",  32'(thresh_hit),  32'(m_thr));
    check("overflow",    32'(overflow),    32'(m_ovf));
    if (delta_valid) dv_count++;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    int dv0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    reset = 1'b1; count_in = 4'hA; clr = 1'b0; threshold = 8'd200;

    // Reset with a nonzero counter: nothing accepted until A has been stable long enough.
    step(3);
    check("rst_total", 32'(total), 0);
    reset = 1'b0;
    step(1);
    check("post_rst_dv", 32'(delta_valid), 0);
    check("post_rst_sync", 32'(count_sync), 0);
    step(3);
    check("early_dv", 32'(delta_valid), 0);
    step(1);
    check("rst_dv", 32'(delta_valid), 1);
    check("rst_sync", 32'(count_sync), 32'hA);
    check("rst_delta", 32'(delta), 10);
    check("rst_total_a", 32'(total), 10);

    // Increment and wrap.
    count_in = 4'h0; step(6);
    clr = 1'b1; step(1); clr = 1'b0;
    dv0 = dv_count;
    count_in = 4'h3; step(6);
    check("inc_delta", 32'(delta), 3);
    check("inc_total", 32'(total), 3);
    count_in = 4'h1; step(6);
    check("wrap_delta", 32'(delta), 14);
    check("wrap_total", 32'(total), 17);
    check("two_pulses", 32'(dv_count - dv0), 2);

    // Glitch rejection.
    count_in = 4'h0; step(6);
    dv0 = dv_count;
    count_in = 4'h7; step(1);
    count_in = 4'h0; step(6);
    check("glitch_dv", 32'(dv_count - dv0), 0);
    check("glitch_sync", 32'(count_sync), 0);
    check("glitch_total", 32'(total), 32);

    // Threshold: sticky through a threshold change, dropped only by clr.
    clr = 1'b1; step(1); clr = 1'b0;
    threshold = 8'd20;
    for (int i = 1; i <= 22; i++) begin
      count_in = 4'(i);
      step(6);
      if (i == 19) check("thr_below", 32'(thresh_hit), 0);
    end
    check("thr_hit", 32'(thresh_hit), 1);
    threshold = 8'd100; step(10);
    check("thr_sticky", 32'(thresh_hit), 1);
    clr = 1'b1; step(1); clr = 1'b0;
    check("thr_clr", 32'(thresh_hit), 0);
    check("thr_clr_total", 32'(total), 0);

    // Overflow at TOTAL_W = 8: 25 steps of 10 then one of 9.
    threshold = 8'd240;
    for (int i = 0; i < 25; i++) begin
      count_in = count_in + 4'd10;
      step(6);
    end
    check("pre_ovf_total", 32'(total), 250);
    check("pre_ovf_flag", 32'(overflow), 0);
    check("pre_ovf_thr", 32'(thresh_hit), 1);
    count_in = count_in + 4'd9;
    step(4);
    check("ovf_total_pending", 32'(total), 250);
    step(1);
    check("ovf_total", 32'(total), 3);
    check("ovf_flag", 32'(overflow), 1);
    step(1);
    clr = 1'b1; step(1); clr = 1'b0;
    check("ovf_clr_total", 32'(total), 0);
    check("ovf_clr_flag", 32'(overflow), 0);
    check("ovf_clr_thr", 32'(thresh_hit), 0);

    // clr on the acceptance edge of 5 -> 9.
    threshold = 8'd200;
    count_in = 4'h5; step(6);
    count_in = 4'h9; step(4);
    clr = 1'b1; step(1); clr = 1'b0;
    check("clracc_dv", 32'(delta_valid), 1);
    check("clracc_delta", 32'(delta), 4);
    check("clracc_sync", 32'(count_sync), 9);
    check("clracc_total", 32'(total), 0);
    count_in = 4'hB; step(6);
    check("clracc_next", 32'(total), 2);

    // Randomized phase: arbitrary values, holds, glitches, clears, resets.
    for (int i = 0; i < 600; i++) begin
      count_in = 4'($urandom);
      clr      = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) threshold = TW'($urandom);
      step(1);
      clr = 1'b0; reset = 1'b0;
      step($urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
